// File: rtl/load_store_unit.sv
// Data-memory initiator: turns one load/store request into one or two word-aligned
// byte-strobed memory accesses, then assembles and extends the load result.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [3:0]        mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_A0, S_A1, S_LWAIT, S_RESP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Word-aligned address bits that physically exist in data memory.
  localparam logic [31:0] ADDR_MASK = ((32'd1 << DM_ADDRESS) - 32'd1) & 32'hFFFF_FFFC;

  state_e      state_q;
  logic        we_q;
  size_e       size_q;
  logic        sgn_q;
  logic [1:0]  off_q;
  logic        cross_q;
  logic [31:0] w1_q;
  logic [3:0]  hi_wr_q;
  logic [31:0] hi_wdata_q;
  logic [31:0] word0_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_en_q;
  logic [3:0]  mem_wr_q;
  logic [31:0] mem_wdata_q;

  size_e       size_d;
  logic        sgn_d;
  logic [1:0]  off_d;
  logic        cross_d;
  logic [3:0]  mask_d;
  logic [7:0]  strb_d;
  logic [63:0] wide_d;
  logic [31:0] w0_d;
  logic [31:0] w1_d;

  always_comb begin
    size_d = SZ_W;
    sgn_d  = 1'b0;
    case (req_funct3)
      3'b000: begin size_d = SZ_B; sgn_d = 1'b1; end
      3'b001: begin size_d = SZ_H; sgn_d = 1'b1; end
      3'b100: if (!req_we) size_d = SZ_B;
      3'b101: if (!req_we) size_d = SZ_H;
      default: ;
    endcase
    off_d   = req_addr[1:0];
    cross_d = (size_d == SZ_H && off_d == 2'd3) || (size_d == SZ_W && off_d != 2'd0);
    case (size_d)
      SZ_B:    mask_d = 4'b0001;
      SZ_H:    mask_d = 4'b0011;
      default: mask_d = 4'b1111;
    endcase
    strb_d = {4'b0000, mask_d} << off_d;
    // Low half feeds the first word, high half spills into the next word.
    wide_d = {32'd0, req_wdata} << {off_d, 3'b000};
    w0_d   = req_addr & ADDR_MASK;
    w1_d   = (w0_d + 32'd4) & ADDR_MASK;
  end

  logic [31:0] ld_lo;
  logic [31:0] ld_hi;
  logic [31:0] ld_q;
  logic [31:0] ld_result;

  always_comb begin
    ld_lo = cross_q ? word0_q : mem_rdata;
    ld_hi = cross_q ? mem_rdata : 32'd0;
    ld_q  = 32'({ld_hi, ld_lo} >> {off_q, 3'b000});
    case (size_q)
      SZ_B:    ld_result = {{24{sgn_q & ld_q[7]}}, ld_q[7:0]};
      SZ_H:    ld_result = {{16{sgn_q & ld_q[15]}}, ld_q[15:0]};
      default: ld_result = ld_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_W;
      sgn_q        <= 1'b0;
      off_q        <= 2'd0;
      cross_q      <= 1'b0;
      w1_q         <= 32'd0;
      hi_wr_q      <= 4'd0;
      hi_wdata_q   <= 32'd0;
      word0_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            cross_q     <= cross_d;
            w1_q        <= w1_d;
            hi_wr_q     <= strb_d[7:4];
            hi_wdata_q  <= wide_d[63:32];
            mem_addr_q  <= w0_d;
            mem_rd_en_q <= !req_we;
            mem_wr_q    <= req_we ? strb_d[3:0] : 4'd0;
            mem_wdata_q <= req_we ? wide_d[31:0] : 32'd0;
            state_q     <= S_A0;
          end
        end
        S_A0: begin
          if (cross_q) begin
            mem_addr_q  <= w1_q;
            mem_rd_en_q <= !we_q;
            mem_wr_q    <= we_q ? hi_wr_q : 4'd0;
            mem_wdata_q <= we_q ? hi_wdata_q : 32'd0;
            state_q     <= S_A1;
          end else begin
            mem_rd_en_q <= 1'b0;
            mem_wr_q    <= 4'd0;
            if (we_q) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'd0;
              state_q      <= S_RESP;
            end else begin
              state_q <= S_LWAIT;
            end
          end
        end
        S_A1: begin
          mem_rd_en_q <= 1'b0;
          mem_wr_q    <= 4'd0;
          word0_q     <= mem_rdata;
          if (we_q) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= 32'd0;
            state_q      <= S_RESP;
          end else begin
            state_q <= S_LWAIT;
          end
        end
        S_LWAIT: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ld_result;
          state_q      <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory interface. Sits between the EX/MEM stage and the word-organised, byte-strobed data memory.
- Accepts one load or store per handshake and issues word-aligned memory accesses with per-byte write strobes.
- Splits accesses that cross a word boundary into two memory accesses.
- Assembles returned words, then sign- or zero-extends load results.

Parameters:
- DM_ADDRESS, 9, number of byte-address bits implemented by data memory; memory addresses wrap modulo 2^DM_ADDRESS.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load data; 0 for stores.
- mem_addr  out  32  word address; bits [1:0] and bits above DM_ADDRESS-1 are 0.
- mem_rd_en  out  1  read strobe.
- mem_wr  out  4  byte write strobes; bit i writes byte lane i.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read word, valid the cycle after mem_rd_en is high.

Behaviour:
- Reset:
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, mem_rd_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - req_ready = (state==IDLE) && !reset.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - All req_* fields are captured at acceptance; later changes are ignored.
  - req_ready is 0 in every state except IDLE.
  - There is no resp back-pressure.
- Width decode:
  - 000 = byte signed (LB/SB); 001 = half signed (LH/SH); 010 = word; 100 = byte unsigned (LBU); 101 = half unsigned (LHU).
  - Any other code is treated as 010.
  - For stores, 100 and 101 are treated as 010.
- Offset and crossing: off = addr[1:0]. Crossing = (half && off==3) || (word && off!=0). Bytes never cross.
- Word addresses: w0 = addr & ~3; w1 = (w0+4) mod 2^DM_ADDRESS, so the top word wraps to 0.
- Store lanes:
  - m = 0001 (byte), 0011 (half) or 1111 (word); s = m << off, 8 bits wide.
  - Word0: mem_wr = s[3:0], mem_wdata = wdata << 8*off.
  - Word1: mem_wr = s[7:4], mem_wdata = wdata >> 8*(4-off).
  - mem_wr is 0 in every non-write cycle.
- Load assembly: q = {word1, word0} >> 8*off, with word1 = 0 if not crossing. Take q[7:0] or q[15:0], sign- or zero-extend per code; word loads take q[31:0].
- FSM states: IDLE, A0, A1, LWAIT, RESP. Memory outputs are registered and driven in the named state.
  - IDLE: on accept, go to A0.
  - A0: drive w0; mem_rd_en=1 for loads, store strobes for stores. Next state: A1 if crossing; else LWAIT for loads; else RESP.
  - A1: drive w1 (read or word1 store strobes). Loads capture word0 from mem_rdata at the end of A1. Next state: LWAIT for loads, RESP for stores.
  - LWAIT: no memory strobes. Capture the final mem_rdata word (word0 if non-crossing, word1 if crossing). Go to RESP.
  - RESP: resp_valid=1 and resp_rdata valid for exactly this cycle. Go to IDLE.
- Latency, accept edge to resp_valid cycle:
  - Aligned store: 2.
  - Crossing store: 3.
  - Aligned load: 3.
  - Crossing load: 4.
- resp_rdata holds its value after RESP until the next RESP.
- Reset mid-operation: the access is abandoned, no resp_valid is produced, all strobes are 0 the next cycle, and memory writes already issued remain.

Test Plan:
- LW, addr=0x010, memory word 0x11223344 -> one read at mem_addr=0x010; resp_valid 3 cycles after accept; resp_rdata=0x11223344.
- LB and LBU, addr=0x023, word 0x80FFFFFF -> LB returns 0xFFFFFF80; LBU returns 0x00000080; one read each.
- SH, addr=0x041, wdata=0x0000ABCD -> single write: mem_addr=0x040, mem_wr=0110, mem_wdata[23:8]=0xABCD; resp_valid 2 cycles after accept.
- SW, addr=0x062, wdata=0xDEADBEEF -> first write: 0x060, mem_wr=1100, lanes[31:16]=0xBEEF. Second write: 0x064, mem_wr=0011, lanes[15:0]=0xDEAD. resp 3 cycles after accept.
- LHU crossing, addr=0x1FF (top of 512 B), word@0x1FC=0xAA000000, word@0x000=0x000000BB -> reads 0x1FC then 0x000 (wrap); resp_rdata=0x0000BBAA after 4 cycles.
- Reset asserted while in A1 of a crossing load -> next cycle mem_rd_en=0, mem_wr=0, req_ready=1; no resp_valid ever pulses for that request.
